databus_arbiter: RTL

- Shares one external memory databus between N accelerator units: VRead and VWrite instances inside a Versat accelerator.
- Each unit exposes a databus master port (valid/ready/addr/wdata/wstrb/len/last, plus shared rdata).
- Grants one master at a time with round-robin priority and holds the grant for a whole burst.
- Exposes the single downstream databus port, plus status and error outputs.

---
 rtl/databus_arbiter_pkg.sv | 17 +
 rtl/databus_arbiter_rr_priority_select.sv | 31 +++
 rtl/databus_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/databus_arbiter_pkg.sv
// Shared definitions for the databus arbiter and its round-robin selector.
package databus_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int N_MASTERS_DEF = 3;
    localparam int LEN_W_DEF     = 8;

    // Index width that stays legal for a single-entry vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/databus_arbiter_rr_priority_select.sv
// Round-robin selector: first asserted request strictly after ptr, wrapping modulo N.
module rr_priority_select #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        // ptr itself is visited last, so the previous owner has lowest priority.
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/databus_arbiter.sv
// Burst-granular round-robin arbiter sharing one downstream databus among N masters.
module databus_arbiter
    import databus_arbiter_pkg::*;
#(
    parameter int N_MASTERS  = N_MASTERS_DEF,
    parameter int AXI_ADDR_W = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = LEN_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_MASTERS-1:0]            databus_valid,
    output logic [N_MASTERS-1:0]            databus_ready,
    input  logic [N_MASTERS*AXI_ADDR_W-1:0] databus_addr,
    input  logic [N_MASTERS*DATA_W-1:0]     databus_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0]   databus_wstrb,
    input  logic [N_MASTERS*LEN_W-1:0]      databus_len,
    output logic [N_MASTERS-1:0]            databus_last,
    output logic [DATA_W-1:0]               databus_rdata,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [AXI_ADDR_W-1:0]           m_addr,
    output logic [DATA_W-1:0]               m_wdata,
    output logic [DATA_W/8-1:0]             m_wstrb,
    output logic [LEN_W-1:0]                m_len,
    input  logic                            m_last,
    input  logic [DATA_W-1:0]               m_rdata,
    output logic [N_MASTERS-1:0]            grant,
    output logic                            busy,
    output logic                            len_err
);

    localparam int IDX_W  = idx_w(N_MASTERS);
    localparam int STRB_W = DATA_W / 8;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [LEN_W-1:0] beat_cnt;

    logic [N_MASTERS-1:0] win_onehot;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_any;

    logic beat, at_len, burst_end, len_bad;

    rr_priority_select #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_sel (
        .req    (databus_valid),
        .ptr    (rr_ptr),
        .onehot (win_onehot),
        .idx    (win_idx),
        .any    (win_any)
    );

    // grant is zero outside BURST, so the mux also forces idle outputs to zero.
    always_comb begin
        m_valid       = 1'b0;
        m_addr        = '0;
        m_wdata       = '0;
        m_wstrb       = '0;
        m_len         = '0;
        databus_ready = '0;
        databus_last  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant[i]) begin
                m_valid          = databus_valid[i];
                m_addr           = databus_addr[i*AXI_ADDR_W +: AXI_ADDR_W];
                m_wdata          = databus_wdata[i*DATA_W +: DATA_W];
                m_wstrb          = databus_wstrb[i*STRB_W +: STRB_W];
                m_len            = databus_len[i*LEN_W +: LEN_W];
                databus_ready[i] = m_ready;
                databus_last[i]  = m_last;
            end
        end
    end

    assign databus_rdata = m_rdata;
    assign busy          = (state == BURST);

    assign beat      = m_valid & m_ready;
    assign at_len    = (beat_cnt == m_len);
    assign burst_end = beat & (m_last | at_len);
    // Either the count ran out without m_last, or m_last came early.
    assign len_bad   = beat & ((at_len & ~m_last) | (m_last & (beat_cnt < m_len)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= IDX_W'(N_MASTERS - 1);
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        grant    <= win_onehot;
                        rr_ptr   <= win_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (len_bad)
                        len_err <= 1'b1;
                    if (burst_end) begin
                        grant <= '0;
                        state <= IDLE;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
